ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
// - Programming controller for the fabric configuration chain (ccff_head -> tiles -> ccff_tail).
// - Accepts bitstream words over valid/ready, serializes them LSB-first onto ccff_head, gates chain shifting, optionally verifies by reload-and-compare.
// - Holds IO isolation active (IO_ISOL_N=0) until a load completes cleanly; sits at fabric top, feeding the first tile's ccff_head.
// PARAMETERS
// - CHAIN_LEN  default 1024  total config bits in chain (>= 2)
// - WORD_W     default 8     bitstream word width (>= 1)
// - CNT_W      default $clog2(CHAIN_LEN+1)  bit-counter width; mismatch_cnt width
// PORTS
// - prog_clk      in   1       programming clock; all state on rising edge
// - prog_reset    in   1       asynchronous, active-high reset
// - start         in   1       1-cycle pulse: begin load; ignored while busy
// - verify_en     in   1       sampled at start: 1 = two passes (load + verify)
// - s_data        in   WORD_W  bitstream word, bit 0 shifted first
// - s_valid       in   1       s_data valid
// - s_ready       out  1       word accepted when s_valid & s_ready
// - ccff_head     out  1       serial config data into chain
// - ccff_clk_en   out  1       enable for external prog_clk ICG on chain; chain advances only when 1
// - ccff_tail     in   1       serial output of last chain flop
// - IO_ISOL_N     out  1       0 = IOs isolated; 1 = released
// - busy          out  1       high in LOAD/VERIFY
// - done          out  1       sticky, load (and verify) finished without mismatch
// - error         out  1       sticky, verify found >= 1 mismatch
// - mismatch_cnt  out  CNT_W   saturating count of verify mismatches
// BEHAVIOUR
// - Reset: state IDLE; s_ready=0, ccff_head=0, ccff_clk_en=0, IO_ISOL_N=0, busy=0, done=0, error=0, mismatch_cnt=0, counters cleared.
// - States: IDLE -start-> LOAD; LOAD -CHAIN_LEN bits shifted-> VERIFY if verify_en latched else DONE;
//   VERIFY -CHAIN_LEN bits shifted-> DONE if mismatch_cnt==0 else FAIL; DONE/FAIL -start-> LOAD.
// - Entering LOAD: done, error, mismatch_cnt cleared; IO_ISOL_N forced 0 same edge.
// - Serializer: 1-word buffer + bit index. s_ready=1 in LOAD/VERIFY when buffer empty, or when last in-word bit
//   (or last chain bit of pass) shifts this cycle; gives back-to-back words at 1 bit/cycle. s_ready=0 in IDLE/DONE/FAIL.
// - Shift cycle: buffer holds a bit -> ccff_clk_en=1, ccff_head=buf[idx] (combinational from registers), bit counter +1.
//   Buffer empty -> ccff_clk_en=0 (chain stalls, no garbage shifted); ccff_head holds last value.
// - Pass end: after bit CHAIN_LEN-1 of a pass, remaining bits of current word discarded; counter resets to 0 for next pass.
//   CHAIN_LEN not a multiple of WORD_W: each pass consumes ceil(CHAIN_LEN/WORD_W) words.
// - Verify: host resends identical bitstream. Each VERIFY shift cycle compares ccff_tail (pre-edge) with ccff_head;
//   unequal -> mismatch_cnt +1, saturating at 2^CNT_W-1. Chain ends holding the pass-2 data.
// - Completion: DONE entered -> done=1, busy=0, IO_ISOL_N=1 next cycle. FAIL -> error=1, IO_ISOL_N stays 0.
// - Latency: start -> s_ready=1 one cycle later; last accepted bit -> done=1 one cycle after its shift edge.
// - start while busy: ignored. start same cycle as final shift: ignored (state still busy).
// - Reset mid-load: immediate return to reset values; chain content undefined; IO_ISOL_N=0.
// STRUCTURE
// - Package ccff_ctrl_pkg: state enum {IDLE, LOAD, VERIFY, DONE, FAIL}, default CHAIN_LEN/WORD_W constants.
// - Sub-module ccff_word_serializer: word buffer, bit index, s_ready/ccff_clk_en generation; top holds FSM, counters, compare.
// - Testbench chain model: CHAIN_LEN-deep shift register clocked by prog_clk & ccff_clk_en.
// TESTING
// - CHAIN_LEN=20, WORD_W=8, verify_en=0, 3 words 0xA5,0x3C,0x0F, s_valid always 1 -> 20 enable cycles, chain = bits 0..19, done=1, IO_ISOL_N=1, 4 MSBs of 0x0F dropped.
// - Same stream, verify_en=1, sent twice -> 40 enable cycles, mismatch_cnt=0, done=1, error=0.
// - Verify pass with bit 5 flipped (0xA5->0x85) -> mismatch_cnt=1, error=1, done=0, IO_ISOL_N=0.
// - s_valid toggling 1/0 every 3 cycles -> ccff_clk_en low on every starved cycle; chain content identical to case 1.
// - prog_reset asserted after 10 bits of LOAD -> all outputs at reset values same cycle; new start reloads cleanly to done=1.
// - start pulsed during LOAD and in final-shift cycle -> ignored; exactly 20 shifts, single done.

Source files
------------

// File: rtl/ccff_ctrl_pkg.sv
// Shared types and defaults for the configuration-chain programming controller.
package ccff_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, FAIL} state_t;
  localparam int DEF_CHAIN_LEN = 1024;
  localparam int DEF_WORD_W    = 8;
endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) from the host into the chain loader.
interface ccff_chain_loader_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  modport master (output s_data, s_valid, input s_ready);
  modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// One-word buffer that feeds ccff_head LSB-first and gates the chain clock enable.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              at_last_bit,
  input  logic              final_pass,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              shift,
  output logic              head
);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] buf_q;
  logic              buf_vld;
  logic [IDX_W-1:0]  idx;
  logic              head_q;
  logic              pass_end, word_end, take;

  assign shift    = active & buf_vld;
  assign pass_end = shift & at_last_bit;
  // A pass end discards whatever is left of the current word.
  assign word_end = shift & ((idx == IDX_W'(WORD_W-1)) | at_last_bit);
  // No refill on the last shift of the whole load: the controller leaves busy next edge.
  assign s_ready  = active & (~buf_vld | word_end) & ~(pass_end & final_pass);
  assign take     = s_valid & s_ready;
  assign head     = buf_vld ? buf_q[idx] : head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      buf_vld <= 1'b0;
      idx     <= '0;
      head_q  <= 1'b0;
    end else begin
      if (shift) head_q <= buf_q[idx];
      if (!active) begin
        buf_vld <= 1'b0;
        idx     <= '0;
      end else if (take) begin
        buf_q   <= s_data;
        buf_vld <= 1'b1;
        idx     <= '0;
      end else if (word_end) begin
        buf_vld <= 1'b0;
        idx     <= '0;
      end else if (shift) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/ccff_chain_loader.sv
// Fabric configuration-chain loader: serializes the bitstream, optionally verifies, releases IO isolation.
module ccff_chain_loader
  import ccff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             start,
  input  logic             verify_en,
  ccff_chain_loader_if.slave bus,
  output logic             ccff_head,
  output logic             ccff_clk_en,
  input  logic             ccff_tail,
  output logic             IO_ISOL_N,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] mismatch_cnt
);
  state_t           state_q, state_d;
  logic             verify_q, done_q, error_q, iso_n_q;
  logic [CNT_W-1:0] bit_cnt, mis_q;
  logic             shift, at_last_bit, pass_end, final_pass, miss, enter_load;

  assign busy        = (state_q == LOAD) | (state_q == VERIFY);
  assign at_last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign pass_end    = shift & at_last_bit;
  assign final_pass  = (state_q == VERIFY) | ((state_q == LOAD) & ~verify_q);
  // ccff_tail is the pre-edge output of the last flop, aligned with the bit now on ccff_head.
  assign miss        = (state_q == VERIFY) & shift & (ccff_tail != ccff_head);
  assign enter_load  = (state_d == LOAD) & (state_q != LOAD);

  assign ccff_clk_en  = shift;
  assign IO_ISOL_N    = iso_n_q;
  assign done         = done_q;
  assign error        = error_q;
  assign mismatch_cnt = mis_q;

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (prog_clk),
    .rst        (prog_reset),
    .active     (busy),
    .at_last_bit(at_last_bit),
    .final_pass (final_pass),
    .s_data     (bus.s_data),
    .s_valid    (bus.s_valid),
    .s_ready    (bus.s_ready),
    .shift      (shift),
    .head       (ccff_head)
  );

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, FAIL: if (start) state_d = LOAD;
      LOAD:             if (pass_end) state_d = verify_q ? VERIFY : DONE;
      VERIFY:           if (pass_end) state_d = ((mis_q == '0) && !miss) ? DONE : FAIL;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      verify_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      iso_n_q  <= 1'b0;
      bit_cnt  <= '0;
      mis_q    <= '0;
    end else if (enter_load) begin
      verify_q <= verify_en;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      iso_n_q  <= 1'b0;
      bit_cnt  <= '0;
      mis_q    <= '0;
    end else begin
      if (pass_end)   bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + CNT_W'(1);
      if (miss && (mis_q != '1)) mis_q <= mis_q + CNT_W'(1);
      if ((state_d == DONE) && (state_q != DONE)) begin
        done_q  <= 1'b1;
        iso_n_q <= 1'b1;
      end
      if ((state_d == FAIL) && (state_q != FAIL)) error_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural chain and a head-bit scoreboard.
module tb_ccff_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CW = $clog2(CL + 1);

  logic          prog_clk = 1'b0;
  logic          prog_reset, start, verify_en;
  logic          ccff_head, ccff_clk_en, ccff_tail, IO_ISOL_N, busy, done, error;
  logic [CW-1:0] mismatch_cnt;
  logic [CL-1:0] chain = '0;

  ccff_chain_loader_if #(.WORD_W(WW)) bus ();

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .start       (start),
    .verify_en   (verify_en),
    .bus         (bus),
    .ccff_head   (ccff_head),
    .ccff_clk_en (ccff_clk_en),
    .ccff_tail   (ccff_tail),
    .IO_ISOL_N   (IO_ISOL_N),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  // Gated chain: advances only on edges where the enable is high.
  always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  int   checks = 0, failures = 0;
  int   en_cnt = 0, busy_cnt = 0, cyc = 0, done_rises = 0, pass_bits = 0;
  bit   mon_on = 1'b1, done_prev = 1'b0;
  bit   exp_q[$];
  logic [7:0] stream [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every enabled cycle must carry the next scoreboard bit on ccff_head.
  initial forever begin
    @(negedge prog_clk);
    cyc++;
    if (busy) busy_cnt++;
    if (done && !done_prev) done_rises++;
    done_prev = done;
    if (ccff_clk_en) begin
      en_cnt++;
      if (mon_on) begin
        if (exp_q.size() == 0) chk("head_underflow", 32'd1, 32'd0);
        else chk("head_bit", {31'd0, ccff_head}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [CL-1:0] exp_chain(input int base);
    logic [CL-1:0] r;
    logic [7:0]    w;
    for (int i = 0; i < CL; i++) begin
      w = stream[base + i / WW];
      r[CL-1-i] = w[i % WW];
    end
    return r;
  endfunction

  task automatic pulse_start(input bit v);
    verify_en = v;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gap, output bit ok);
    bit hs;
    ok = 1'b0;
    bus.s_data = w;
    for (int t = 0; t < 200; t++) begin
      bus.s_valid = gap ? (((cyc / 3) % 2) == 0) : 1'b1;
      @(negedge prog_clk);
      hs = bus.s_valid & bus.s_ready;
      @(posedge prog_clk); #1;
      if (hs) begin
        for (int b = 0; b < WW; b++)
          if (pass_bits < CL) begin
            exp_q.push_back(w[b]);
            pass_bits++;
          end
        if (pass_bits == CL) pass_bits = 0;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_words(input int n, input bit gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_word(stream[i], gap, ok);
      chk("word_accept", {31'd0, ok}, 32'd1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic begin_load(input bit v);
    pass_bits = 0;
    pulse_start(v);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("start_iso", {31'd0, IO_ISOL_N}, 32'd0);
    chk("start_done_clr", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge prog_clk);
      if (!busy) break;
    end
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.s_ready}, 32'd0);
    chk({tag, "_head"}, {31'd0, ccff_head}, 32'd0);
    chk({tag, "_clk_en"}, {31'd0, ccff_clk_en}, 32'd0);
    chk({tag, "_iso"}, {31'd0, IO_ISOL_N}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_mis"}, {27'd0, mismatch_cnt}, 32'd0);
  endtask

  initial begin
    int e0, b0, d0;
    bit ok;
    prog_reset = 1'b1; start = 1'b0; verify_en = 1'b0;
    bus.s_data = '0; bus.s_valid = 1'b0;
    stream = '{8'hA5, 8'h3C, 8'h0F, 8'hA5, 8'h3C, 8'h0F};
    repeat (2) @(negedge prog_clk);
    chk_reset_vals("rst");
    @(posedge prog_clk); #1 prog_reset = 1'b0;
    repeat (2) @(posedge prog_clk); #1;

    // Plain load, no verify; the top nibble of 0x0F never reaches the chain.
    e0 = en_cnt;
    begin_load(1'b0);
    send_words(3, 1'b0);
    wait_idle();
    chk("c1_en", en_cnt - e0, 32'd20);
    chk("c1_chain", {12'd0, chain}, {12'd0, exp_chain(0)});
    chk("c1_done", {31'd0, done}, 32'd1);
    chk("c1_iso", {31'd0, IO_ISOL_N}, 32'd1);
    chk("c1_error", {31'd0, error}, 32'd0);
    chk("c1_q", exp_q.size(), 32'd0);
    chk("c1_ready_idle", {31'd0, bus.s_ready}, 32'd0);

    // Load + clean verify.
    e0 = en_cnt;
    begin_load(1'b1);
    send_words(6, 1'b0);
    wait_idle();
    chk("c2_en", en_cnt - e0, 32'd40);
    chk("c2_mis", {27'd0, mismatch_cnt}, 32'd0);
    chk("c2_done", {31'd0, done}, 32'd1);
    chk("c2_error", {31'd0, error}, 32'd0);
    chk("c2_iso", {31'd0, IO_ISOL_N}, 32'd1);
    chk("c2_chain", {12'd0, chain}, {12'd0, exp_chain(3)});

    // Verify pass with bit 5 of the first word flipped.
    stream[3] = 8'h85;
    begin_load(1'b1);
    send_words(6, 1'b0);
    wait_idle();
    chk("c3_mis", {27'd0, mismatch_cnt}, 32'd1);
    chk("c3_error", {31'd0, error}, 32'd1);
    chk("c3_done", {31'd0, done}, 32'd0);
    chk("c3_iso", {31'd0, IO_ISOL_N}, 32'd0);
    chk("c3_chain", {12'd0, chain}, {12'd0, exp_chain(3)});
    stream[3] = 8'hA5;

    // Starved source: valid toggles every 3 cycles.
    e0 = en_cnt; b0 = busy_cnt;
    begin_load(1'b0);
    send_words(3, 1'b1);
    wait_idle();
    chk("c4_en", en_cnt - e0, 32'd20);
    chk("c4_stalled", {31'd0, (busy_cnt - b0) > 20}, 32'd1);
    chk("c4_chain", {12'd0, chain}, {12'd0, exp_chain(0)});
    chk("c4_done", {31'd0, done}, 32'd1);

    // Reset after 10 shifted bits, then a clean reload.
    mon_on = 1'b0;
    e0 = en_cnt;
    pulse_start(1'b0);
    bus.s_data = 8'hA5; bus.s_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge prog_clk); #1;
      if (en_cnt - e0 >= 10) break;
    end
    chk("c5_pre_en", en_cnt - e0, 32'd10);
    prog_reset = 1'b1;
    #1;
    chk_reset_vals("c5_rst");
    @(posedge prog_clk); #1;
    prog_reset = 1'b0; bus.s_valid = 1'b0;
    exp_q.delete();
    mon_on = 1'b1;
    begin_load(1'b0);
    send_words(3, 1'b0);
    wait_idle();
    chk("c5_chain", {12'd0, chain}, {12'd0, exp_chain(0)});
    chk("c5_done", {31'd0, done}, 32'd1);

    // Start pulses mid-load and on the final shift cycle are ignored.
    e0 = en_cnt; d0 = done_rises;
    begin_load(1'b0);
    fork
      send_words(3, 1'b0);
      begin
        for (int t = 0; t < 100; t++) begin
          if (en_cnt - e0 >= 5) break;
          @(posedge prog_clk); #1;
        end
        start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        for (int t = 0; t < 100; t++) begin
          if (en_cnt - e0 >= 19) break;
          @(posedge prog_clk); #1;
        end
        start = 1'b1;
        chk("c6_final_shift", {31'd0, ccff_clk_en & busy}, 32'd1);
        @(posedge prog_clk); #1 start = 1'b0;
      end
    join
    wait_idle();
    repeat (5) @(negedge prog_clk);
    chk("c6_en", en_cnt - e0, 32'd20);
    chk("c6_busy", {31'd0, busy}, 32'd0);
    chk("c6_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("c6_done_once", done_rises - d0, 32'd1);
    chk("c6_chain", {12'd0, chain}, {12'd0, exp_chain(0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
